clk_div_prog: RTL and testbench

- Runtime-programmable clock divider / tick generator; successor to the fixed-constant divider.
- Sits between the board oscillator and the single-cycle CPU clock / display-refresh logic.
- Three modes:
  - Divided square wave.
  - One-cycle enable tick.
  - Manual single-step, for debugging the CPU one instruction at a time.
- Divisor reload is glitch-free: a new value takes effect only at a period boundary.

---
 rtl/clk_div_prog.sv | 140 ++++++++++++++
 tb/tb_clk_div_prog.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider and tick generator with
// glitch-free divisor reload and a manual single-step mode.
module clk_div_prog #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 2500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   input  logic             step,
   output logic             clk_out,
   output logic             tick,
   output logic [CNT_W-1:0] div_cur,
   output logic             div_pending
);

   localparam logic [1:0] MODE_TOG  = 2'd0;
   localparam logic [1:0] MODE_TICK = 2'd1;
   localparam logic [1:0] MODE_STEP = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] div_cur_q, div_cur_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             step_q, step_d;
   logic [1:0]       mode_q, mode_d;

   logic mode_chg;
   logic running;
   logic frozen;
   logic tc;
   logic step_rise;
   logic apply;
   logic load_ok;

   always_comb begin
      mode_chg  = (mode != mode_q);
      running   = en && ((mode == MODE_TOG) || (mode == MODE_TICK));
      frozen    = !en || (mode == MODE_RSVD);
      tc        = running && (cnt_q == div_cur_q - ONE);
      step_rise = step && !step_q;
      load_ok   = div_load && (div_in != '0);
   end

   always_comb begin
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      div_cur_d = div_cur_q;
      shadow_d  = shadow_q;
      pend_d    = pend_q;
      apply     = 1'b0;
      step_d    = step;
      mode_d    = mode;

      // A mode switch restarts everything and masks any TC
      if (mode_chg) begin
         cnt_d     = '0;
         clk_out_d = 1'b0;
      end else if (en) begin
         unique case (mode)
            MODE_TOG, MODE_TICK: begin
               if (tc) begin
                  cnt_d = '0;
                  apply = pend_q;
                  if (mode == MODE_TOG) begin
                     clk_out_d = !clk_out_q;
                  end else begin
                     tick_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            MODE_STEP: begin
               cnt_d = '0;
               if (step_rise) begin
                  tick_d    = 1'b1;
                  clk_out_d = !clk_out_q;
               end
            end
            default: begin
            end
         endcase
      end

      // While idle there is no boundary to wait for, so apply at once
      if (frozen && pend_q) begin
         apply = 1'b1;
         cnt_d = '0;
      end

      if (apply) begin
         div_cur_d = shadow_q;
         pend_d    = 1'b0;
      end

      if (load_ok) begin
         shadow_d = div_in;
         pend_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         div_cur_q <= DIV_RST;
         shadow_q  <= '0;
         pend_q    <= 1'b0;
         step_q    <= 1'b0;
         mode_q    <= MODE_TOG;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         div_cur_q <= div_cur_d;
         shadow_q  <= shadow_d;
         pend_q    <= pend_d;
         step_q    <= step_d;
         mode_q    <= mode_d;
      end
   end

   assign clk_out     = clk_out_q;
   assign tick        = tick_q;
   assign div_cur     = div_cur_q;
   assign div_pending = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed plus random bench for clk_div_prog against a
// period-level reference model.
module tb_clk_div_prog;

   localparam int CW = 8;
   localparam int DEF = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [1:0]    mode;
   logic [CW-1:0] div_in;
   logic          div_load;
   logic          step;
   logic          clk_out;
   logic          tick;
   logic [CW-1:0] div_cur;
   logic          div_pending;

   int checks = 0;
   int errors = 0;

   // reference model: position inside the current period
   int m_elapsed;
   int m_period;
   bit m_clk;
   bit m_tick;
   bit m_step_prev;
   int m_mode_prev;
   int m_loads[$];

   clk_div_prog #(
      .CNT_W(CW),
      .DEFAULT_DIV(DEF)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .mode(mode),
      .div_in(div_in),
      .div_load(div_load),
      .step(step),
      .clk_out(clk_out),
      .tick(tick),
      .div_cur(div_cur),
      .div_pending(div_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_elapsed   = 0;
      m_period    = DEF;
      m_clk       = 0;
      m_tick      = 0;
      m_step_prev = 0;
      m_mode_prev = 0;
      m_loads.delete();
   endtask

   task automatic model_edge();
      bit apply;
      apply  = 0;
      m_tick = 0;
      if (int'(mode) != m_mode_prev) begin
         m_elapsed = 0;
         m_clk     = 0;
      end else if (en && mode <= 2'd1) begin
         m_elapsed++;
         if (m_elapsed == m_period) begin
            m_elapsed = 0;
            apply = (m_loads.size() != 0);
            if (mode == 2'd0) m_clk = !m_clk;
            else m_tick = 1;
         end
      end else if (en && mode == 2'd2) begin
         if (step && !m_step_prev) begin
            m_tick = 1;
            m_clk  = !m_clk;
         end
      end
      if ((!en || mode == 2'd3) && m_loads.size() != 0) begin
         apply     = 1;
         m_elapsed = 0;
      end
      if (apply) begin
         m_period = m_loads[$];
         m_loads.delete();
      end
      if (div_load && div_in != 0) m_loads.push_back(int'(div_in));
      m_step_prev = step;
      m_mode_prev = int'(mode);
   endtask

   task automatic check_model();
      chk("clk_out", 32'(clk_out), 32'(m_clk));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("div_cur", 32'(div_cur), 32'(m_period));
      chk("div_pending", 32'(div_pending), 32'(m_loads.size() != 0));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_clk_out"}, 32'(clk_out), 0);
      chk({tag, "_tick"}, 32'(tick), 0);
      chk({tag, "_div_cur"}, 32'(div_cur), DEF);
      chk({tag, "_pending"}, 32'(div_pending), 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   initial begin
      int first_rise;
      int nticks;
      int ntog;
      int gap;
      bit prev;

      rst_n = 0; en = 0; mode = 0; div_in = 0; div_load = 0; step = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset("rst");
      rst_n = 1;
      #2;
      check_reset("rst_rel");

      // toggle mode, default divisor
      en = 1;
      first_rise = -1;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (clk_out && first_rise < 0) first_rise = k;
      end
      chk("first_rise", first_rise, 4);

      // tick mode
      mode = 1;
      cyc();
      nticks = 0;
      for (int k = 0; k < 12; k++) begin
         cyc();
         if (tick) nticks++;
      end
      chk("tick_cnt_div4", nticks, 3);
      repeat (2) cyc();
      div_in = 3; div_load = 1;
      cyc();
      div_load = 0;
      chk("pend_after_load", 32'(div_pending), 1);
      for (int i = 0; i < 12 && div_cur != 3; i++) cyc();
      chk("applied_div3", 32'(div_cur), 3);
      chk("tick_at_apply", 32'(tick), 1);
      for (gap = 1; gap <= 10; gap++) begin
         cyc();
         if (tick) break;
      end
      chk("gap_div3", gap, 3);

      // zero load ignored, last of two loads wins
      div_in = 0; div_load = 1;
      cyc();
      div_load = 0;
      chk("zero_load_pend", 32'(div_pending), 0);
      chk("zero_load_cur", 32'(div_cur), 3);
      for (int i = 0; i < 10 && !tick; i++) cyc();
      div_in = 6; div_load = 1;
      cyc();
      div_in = 2;
      cyc();
      div_load = 0;
      cyc();
      chk("last_load_wins", 32'(div_cur), 2);

      // single-step
      mode = 2; step = 0;
      cyc();
      nticks = 0; ntog = 0; prev = clk_out;
      for (int k = 0; k < 16; k++) begin
         step = (k < 10 || k >= 13);
         cyc();
         if (tick) nticks++;
         if (clk_out != prev) ntog++;
         prev = clk_out;
      end
      chk("step_ticks", nticks, 2);
      chk("step_toggles", ntog, 2);
      step = 0;

      // enable low with a pending load
      mode = 0;
      cyc();
      repeat (2) cyc();
      en = 0; div_in = 5; div_load = 1;
      cyc();
      div_load = 0;
      repeat (4) cyc();
      chk("frz_div_cur", 32'(div_cur), 5);
      chk("frz_pend", 32'(div_pending), 0);
      chk("frz_tick", 32'(tick), 0);
      en = 1;
      prev = clk_out;
      for (gap = 1; gap <= 20; gap++) begin
         cyc();
         if (clk_out != prev) break;
      end
      chk("full_period_after_en", gap, 5);

      // asynchronous reset with a load pending
      div_in = 6; div_load = 1;
      cyc();
      div_load = 0;
      chk("pend_before_rst", 32'(div_pending), 1);
      cyc();
      #2 rst_n = 0;
      #1;
      check_reset("async_rst");
      model_reset();
      mode = 0; en = 1; step = 0;
      @(negedge clk);
      rst_n = 1;
      #1;
      check_reset("async_rel");

      // random traffic
      for (int k = 0; k < 600; k++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
         div_load = ($urandom_range(0, 7) == 0);
         div_in = CW'($urandom_range(0, 6));
         if ($urandom_range(0, 3) == 0) step = !step;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
